// File: rtl/fft_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_params_pkg
// Description : Shared FFT sizing constants, derived widths, the stage
//               address-generator state type and butterfly index helpers.
// Revision    : 1.0  initial release
// ============================================================================
package fft_params_pkg;

    localparam int N       = 256;
    localparam int STAGES  = $clog2(N);
    localparam int ADDR_W  = $clog2(N);
    localparam int TW_W    = ADDR_W - 1;
    localparam int STAGE_W = $clog2(STAGES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } agu_state_t;

    // Top input of butterfly k in stage s: the group index selects a block
    // of 2*half words, the position selects the word inside its top half.
    function automatic int bfly_addr_a(input int k, input int s);
        int pos;
        int grp;
        pos = k & ((1 << s) - 1);
        grp = k >> s;
        return (grp << (s + 1)) | pos;
    endfunction

    function automatic int bfly_addr_b(input int k, input int s);
        return bfly_addr_a(k, s) + (1 << s);
    endfunction

    // Twiddle exponent scaled into the N/2-entry ROM.
    function automatic int bfly_tw_idx(input int k, input int s, input int stages);
        int pos;
        pos = k & ((1 << s) - 1);
        return pos << (stages - 1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_wb_delay.sv
`default_nettype none
// ============================================================================
// Module      : fft_wb_delay
// Description : PIPE_LAT-deep shift register carrying {valid, addr_a, addr_b}
//               from read issue to write-back. One entry (real or bubble) is
//               shifted in every cycle.
// Ports       : clk, rst           clock, async active-high reset
//               in_valid/in_addr_* entry pushed this cycle
//               out_valid/out_addr_* entry leaving the line (write-back)
//               any_valid          a valid entry still has to reach the output
//                                  in a later cycle
// Revision    : 1.0  initial release
// ============================================================================
module fft_wb_delay #(
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr_a,
    input  logic [ADDR_W-1:0] in_addr_b,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr_a,
    output logic [ADDR_W-1:0] out_addr_b,
    output logic              any_valid
);

    logic [PIPE_LAT-1:0] r_valid;
    logic [ADDR_W-1:0]   r_addr_a [PIPE_LAT];
    logic [ADDR_W-1:0]   r_addr_b [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
            end
        end else begin
            r_valid[0]  <= in_valid;
            r_addr_a[0] <= in_addr_a;
            r_addr_b[0] <= in_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign out_valid  = r_valid[PIPE_LAT-1];
    assign out_addr_a = r_addr_a[PIPE_LAT-1];
    assign out_addr_b = r_addr_b[PIPE_LAT-1];

    // The last stage is the entry being written back right now; only the
    // earlier stages represent work that is still outstanding.
    generate
        if (PIPE_LAT == 1) begin : g_any_single
            assign any_valid = 1'b0;
        end else begin : g_any_multi
            assign any_valid = |r_valid[PIPE_LAT-2:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_stage_agu.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_agu
// Description : Per-stage address generator for a radix-2 in-place FFT.
//               Walks the N/2 butterflies of the requested stage, issues the
//               read pair and twiddle index, and replays the read addresses
//               as write-back addresses PIPE_LAT cycles after acceptance.
//               stage_done pulses once the last write-back has retired.
// Ports       : clk, rst                      clock, async active-high reset
//               stage_start, stage_idx        stage request (IDLE only)
//               issue_ready                   datapath accepts a read issue
//               busy, stage_done, err         status to the control FSM
//               rd_en, rd_addr_a/b, tw_idx    read issue
//               wr_en, wr_addr_a/b            write-back
// Revision    : 1.0  initial release
// ============================================================================
module fft_stage_agu #(
    parameter int N        = fft_params_pkg::N,
    parameter int STAGES   = $clog2(N),
    parameter int PIPE_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stage_start,
    input  logic [$clog2(STAGES)-1:0]  stage_idx,
    input  logic                       issue_ready,
    output logic                       busy,
    output logic                       stage_done,
    output logic                       err,
    output logic                       rd_en,
    output logic [$clog2(N)-1:0]       rd_addr_a,
    output logic [$clog2(N)-1:0]       rd_addr_b,
    output logic [$clog2(N)-2:0]       tw_idx,
    output logic                       wr_en,
    output logic [$clog2(N)-1:0]       wr_addr_a,
    output logic [$clog2(N)-1:0]       wr_addr_b
);

    import fft_params_pkg::*;

    localparam int c_ADDR_W  = $clog2(N);
    localparam int c_TW_W    = c_ADDR_W - 1;
    localparam int c_K_W     = c_ADDR_W - 1;
    localparam int c_STAGE_W = $clog2(STAGES);
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(N / 2 - 1);

    agu_state_t           r_state;
    agu_state_t           w_state_nxt;
    logic [c_K_W-1:0]     r_k;
    logic [c_K_W-1:0]     w_k_nxt;
    logic [c_STAGE_W-1:0] r_s;
    logic [c_STAGE_W-1:0] w_s_nxt;

    logic                 w_start_ok;
    logic                 w_start_bad;
    logic                 w_accept;
    logic                 w_any_valid;
    logic                 r_err;

    logic [c_ADDR_W-1:0]  r_rd_addr_a;
    logic [c_ADDR_W-1:0]  r_rd_addr_b;
    logic [c_TW_W-1:0]    r_tw_idx;
    logic [c_ADDR_W-1:0]  w_rd_addr_a_nxt;
    logic [c_ADDR_W-1:0]  w_rd_addr_b_nxt;
    logic [c_TW_W-1:0]    w_tw_idx_nxt;

    logic [c_ADDR_W-1:0]  w_push_addr_a;
    logic [c_ADDR_W-1:0]  w_push_addr_b;

    assign w_start_ok  = (r_state == IDLE) && stage_start && (int'(stage_idx) <  STAGES);
    assign w_start_bad = (r_state == IDLE) && stage_start && (int'(stage_idx) >= STAGES);
    assign w_accept    = (r_state == ISSUE) && issue_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_s     <= w_s_nxt;
            r_err   <= w_start_bad;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ISSUE;
                    w_k_nxt     = '0;
                    w_s_nxt     = stage_idx;
                end
            end
            ISSUE: begin
                if (w_accept) begin
                    if (r_k == c_K_LAST) begin
                        w_state_nxt = DRAIN;
                        w_k_nxt     = '0;
                    end else begin
                        w_k_nxt     = r_k + c_K_W'(1);
                    end
                end
            end
            DRAIN: begin
                // The entry at the delay-line output is written this cycle,
                // so stage_done next cycle follows the final write-back.
                if (!w_any_valid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (r_state != IDLE);
        rd_en      = (r_state == ISSUE);
        stage_done = (r_state == DONE);
    end

    assign err = r_err;

    // Read addresses are registered from the next k/s so that in ISSUE they
    // always describe butterfly r_k of stage r_s, and are zero elsewhere.
    always_comb begin
        w_rd_addr_a_nxt = '0;
        w_rd_addr_b_nxt = '0;
        w_tw_idx_nxt    = '0;
        if (w_state_nxt == ISSUE) begin
            w_rd_addr_a_nxt = c_ADDR_W'(bfly_addr_a(int'(w_k_nxt), int'(w_s_nxt)));
            w_rd_addr_b_nxt = c_ADDR_W'(bfly_addr_b(int'(w_k_nxt), int'(w_s_nxt)));
            w_tw_idx_nxt    = c_TW_W'(bfly_tw_idx(int'(w_k_nxt), int'(w_s_nxt), STAGES));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_idx    <= '0;
        end else begin
            r_rd_addr_a <= w_rd_addr_a_nxt;
            r_rd_addr_b <= w_rd_addr_b_nxt;
            r_tw_idx    <= w_tw_idx_nxt;
        end
    end

    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign tw_idx    = r_tw_idx;

    // Bubbles carry zero addresses so the write-back bus idles at zero.
    assign w_push_addr_a = w_accept ? r_rd_addr_a : '0;
    assign w_push_addr_b = w_accept ? r_rd_addr_b : '0;

    fft_wb_delay #(
        .PIPE_LAT (PIPE_LAT),
        .ADDR_W   (c_ADDR_W)
    ) u_wb_delay (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (w_accept),
        .in_addr_a  (w_push_addr_a),
        .in_addr_b  (w_push_addr_b),
        .out_valid  (wr_en),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b),
        .any_valid  (w_any_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_agu.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_agu
// Description : Self-checking bench for fft_stage_agu. A stage reference is
//               built from group/position arithmetic; accepted issues are
//               queued with their due write-back cycle and matched against
//               the write-back bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fft_stage_agu;

    localparam int N      = 256;
    localparam int PL     = 4;
    localparam int HALF_N = N / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       stage_start;
    logic [2:0] stage_idx;
    logic       issue_ready;
    logic       busy, stage_done, err, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_idx;

    // Second instance: N=64 gives STAGES=6 with a 3-bit stage_idx,
    // so indices 6 and 7 are out of range.
    logic       stage_start6;
    logic [2:0] stage_idx6;
    logic       issue_ready6;
    logic       busy6, stage_done6, err6, rd_en6, wr_en6;
    logic [5:0] rd_addr_a6, rd_addr_b6, wr_addr_a6, wr_addr_b6;
    logic [4:0] tw_idx6;

    always #5 clk = ~clk;

    fft_stage_agu #(.N(N), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .stage_start(stage_start), .stage_idx(stage_idx),
        .issue_ready(issue_ready), .busy(busy), .stage_done(stage_done), .err(err),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_stage_agu #(.N(64), .PIPE_LAT(PL)) dut6 (
        .clk(clk), .rst(rst), .stage_start(stage_start6), .stage_idx(stage_idx6),
        .issue_ready(issue_ready6), .busy(busy6), .stage_done(stage_done6), .err(err6),
        .rd_en(rd_en6), .rd_addr_a(rd_addr_a6), .rd_addr_b(rd_addr_b6), .tw_idx(tw_idx6),
        .wr_en(wr_en6), .wr_addr_a(wr_addr_a6), .wr_addr_b(wr_addr_b6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference butterfly order for one stage: groups of 2*half words,
    // each group pairing word p with word p+half, twiddle p*groups.
    int ref_a  [HALF_N];
    int ref_b  [HALF_N];
    int ref_tw [HALF_N];

    function automatic void build_ref(input int s);
        int half;
        int groups;
        int idx;
        half   = 2 ** s;
        groups = N / (2 * half);
        idx    = 0;
        for (int g = 0; g < groups; g++) begin
            for (int p = 0; p < half; p++) begin
                ref_a[idx]  = g * 2 * half + p;
                ref_b[idx]  = g * 2 * half + p + half;
                ref_tw[idx] = p * groups;
                idx++;
            end
        end
    endfunction

    typedef struct {
        int due;
        int a;
        int b;
    } wb_t;

    wb_t wq[$];

    // mode 0: always ready; 1: ready 1,0,1,0...; 2: random, mostly ready
    function automatic logic pick_ready(input int mode, input int rel);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (rel % 2) == 1;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_stage(input int s, input int mode, input int inject_at, input int abort_at);
        int  rel, n_acc, n_wr, last_wr, done_cyc, first_rd, act;
        bit  fin, aborted;
        wb_t e;
        build_ref(s);
        wq.delete();
        n_acc = 0; n_wr = 0; last_wr = -1; done_cyc = -1; first_rd = -1;
        fin = 0; aborted = 0;

        @(posedge clk); #1;
        stage_start = 1'b1;
        stage_idx   = 3'(s);
        @(negedge clk);
        chk("idle_busy_before_start", 32'(busy), 0);
        chk("idle_done_before_start", 32'(stage_done), 0);
        @(posedge clk); #1;
        stage_start = 1'b0;
        stage_idx   = 3'($urandom);
        rel         = 1;
        issue_ready = pick_ready(mode, rel);

        while (!fin && rel < 3000) begin
            @(negedge clk);
            if (rel == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_rd_en", 32'(rd_en), 0);
                chk("rst_rd_addr_a", 32'(rd_addr_a), 0);
                chk("rst_rd_addr_b", 32'(rd_addr_b), 0);
                chk("rst_tw_idx", 32'(tw_idx), 0);
                chk("rst_wr_en", 32'(wr_en), 0);
                chk("rst_wr_addr_a", 32'(wr_addr_a), 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                issue_ready = 1'b1;
                act = 0;
                repeat (150) begin
                    @(negedge clk);
                    if (wr_en || rd_en || stage_done || busy) act++;
                end
                chk("quiet_after_rst", act, 0);
                fin     = 1;
                aborted = 1;
            end else begin
                chk("busy", 32'(busy), 1);
                if (rd_en) begin
                    if (first_rd < 0) first_rd = rel;
                    if (n_acc < HALF_N) begin
                        chk("rd_addr_a", 32'(rd_addr_a), ref_a[n_acc]);
                        chk("rd_addr_b", 32'(rd_addr_b), ref_b[n_acc]);
                        chk("tw_idx", 32'(tw_idx), ref_tw[n_acc]);
                        if (issue_ready) begin
                            e.due = rel + PL; e.a = ref_a[n_acc]; e.b = ref_b[n_acc];
                            wq.push_back(e);
                            n_acc++;
                        end
                    end else begin
                        chk("rd_en_after_last", 32'(rd_en), 0);
                    end
                end
                if (wq.size() > 0 && wq[0].due == rel) begin
                    e = wq.pop_front();
                    chk("wr_en", 32'(wr_en), 1);
                    chk("wr_addr_a", 32'(wr_addr_a), e.a);
                    chk("wr_addr_b", 32'(wr_addr_b), e.b);
                    n_wr++;
                    last_wr = rel;
                end else begin
                    chk("wr_en_unexpected", 32'(wr_en), 0);
                end
                if (stage_done) begin
                    done_cyc = rel;
                    fin      = 1;
                end
                @(posedge clk); #1;
                rel++;
                issue_ready = pick_ready(mode, rel);
                if (rel == inject_at) begin
                    stage_start = 1'b1;
                    stage_idx   = 3'($urandom);
                end else begin
                    stage_start = 1'b0;
                end
            end
        end
        stage_start = 1'b0;

        if (!aborted) begin
            chk("stage_done_seen", 32'(fin), 1);
            chk("first_rd_cycle", first_rd, 1);
            chk("accept_count", n_acc, HALF_N);
            chk("write_count", n_wr, HALF_N);
            chk("pending_writebacks", wq.size(), 0);
            chk("done_after_last_wr", done_cyc, last_wr + 1);
            if (mode == 0) chk("done_cycle", done_cyc, HALF_N + PL + 1);
        end
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        stage_start = 1'b0; stage_idx = '0; issue_ready = 1'b0;
        stage_start6 = 1'b0; stage_idx6 = '0; issue_ready6 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_stage_done", 32'(stage_done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_rd_en", 32'(rd_en), 0);
        chk("reset_rd_addr_a", 32'(rd_addr_a), 0);
        chk("reset_rd_addr_b", 32'(rd_addr_b), 0);
        chk("reset_tw_idx", 32'(tw_idx), 0);
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr_b", 32'(wr_addr_b), 0);
        @(posedge clk); #1 rst = 1'b0;

        run_stage(0, 0, -1, -1);
        run_stage(7, 0, -1, -1);
        run_stage(0, 0, -1, -1);        // started in the cycle after DONE
        run_stage(2, 2, 10, -1);        // stray stage_start mid-stage
        run_stage(3, 1, -1, -1);
        run_stage(4, 0, -1, 60);        // reset mid-stage
        run_stage(4, 2, -1, -1);
        repeat (3) run_stage($urandom_range(0, 7), 2, $urandom_range(3, 150), -1);

        // Out-of-range requests on the six-stage instance
        for (int idx = 6; idx < 8; idx++) begin
            @(posedge clk); #1;
            stage_start6 = 1'b1;
            stage_idx6   = 3'(idx);
            @(posedge clk); #1;
            stage_start6 = 1'b0;
            @(negedge clk);
            chk("oor_err_pulse", 32'(err6), 1);
            chk("oor_busy", 32'(busy6), 0);
            cnt = 0;
            repeat (5) begin
                @(negedge clk);
                if (err6 || busy6 || rd_en6 || wr_en6) cnt++;
            end
            chk("oor_quiet_after", cnt, 0);
        end

        // Valid request on the six-stage instance
        @(posedge clk); #1;
        stage_start6 = 1'b1;
        stage_idx6   = 3'd5;
        @(posedge clk); #1;
        stage_start6 = 1'b0;
        @(negedge clk);
        chk("small_busy", 32'(busy6), 1);
        chk("small_err", 32'(err6), 0);
        cnt = 0;
        for (int c = 0; c < 200 && !stage_done6; c++) begin
            if (wr_en6) cnt++;
            @(negedge clk);
        end
        chk("small_done_seen", 32'(stage_done6), 1);
        chk("small_write_count", cnt, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_stage_agu.md
Name: fft_stage_agu

Overview:
- Responder to the FFT control FSM's stage handshake. It accepts stage_start and stage_idx, walks all N/2 radix-2 butterflies of that stage, and returns a one-cycle stage_done pulse once the stage's last write-back has retired.
- Generates the ping-pong memory read pair addresses, the twiddle ROM index, and the write-back addresses, delayed to match the fixed read-plus-butterfly pipeline latency.
- Sits between fft_control_fsm and the memory/butterfly datapath.

Parameters:
- N, 256, FFT length; power of two, at least 4.
- STAGES, $clog2(N) = 8, number of radix-2 stages.
- PIPE_LAT, 4, cycles from an accepted read issue to its butterfly result being ready for write-back; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stage_start  in  1  one-cycle request from the control FSM; honoured only in IDLE.
- stage_idx  in  STAGE_W=$clog2(STAGES)  stage to run; sampled with stage_start.
- issue_ready  in  1  datapath can accept a read issue this cycle.
- busy  out  1  high in any state other than IDLE.
- stage_done  out  1  one-cycle pulse when the stage has completed.
- err  out  1  one-cycle pulse when stage_start arrives with stage_idx >= STAGES.
- rd_en  out  1  read issue valid; the issue is accepted when rd_en && issue_ready.
- rd_addr_a  out  ADDR_W=$clog2(N)  top butterfly input address.
- rd_addr_b  out  ADDR_W  bottom butterfly input address.
- tw_idx  out  ADDR_W-1  twiddle ROM index.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  ADDR_W  top result address.
- wr_addr_b  out  ADDR_W  bottom result address.

Behaviour:
- Reset: state=IDLE. Butterfly counter k=0, latched stage s=0, delay-line valid bits all 0. All outputs are 0.
- Reset mid-stage: all in-flight issues are discarded. No wr_en or stage_done may appear after rst deasserts until a new stage_start.
- Address math for butterfly k in 0..N/2-1, with half=1<<s:
  - pos = k & (half-1).
  - grp = k >> s.
  - rd_addr_a = (grp << (s+1)) | pos.
  - rd_addr_b = rd_addr_a + half.
  - tw_idx = pos << (STAGES-1-s).
- All address outputs are registered and are functions of the registered k and s only.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - stage_start with stage_idx < STAGES: latch s, set k=0, go to ISSUE.
  - stage_start with stage_idx >= STAGES: pulse err the next cycle, stay in IDLE.
- ISSUE:
  - rd_en=1.
  - On acceptance: push {rd_addr_a, rd_addr_b} into a PIPE_LAT-deep delay line with valid=1, then k++.
  - No acceptance: push a bubble (valid=0). k and the addresses hold stable while issue_ready=0.
  - Acceptance with k == N/2-1: go to DRAIN; rd_en drops the next cycle.
- DRAIN:
  - rd_en=0; bubbles keep shifting in.
  - Go to DONE when the delay line holds no valid entries and none is emerging this cycle.
- DONE: stage_done=1 for exactly one cycle, then IDLE.
- Write-back:
  - wr_en, wr_addr_a and wr_addr_b equal the delay-line output.
  - Write-back fires exactly PIPE_LAT cycles after the corresponding accepted issue, in every state, and is independent of issue_ready.
- Every stage produces exactly N/2 rd accepts and exactly N/2 wr_en pulses.
- Ordering: stage_done asserts only after the final wr_en, so the next stage never reads stale data.
- stage_start arriving in ISSUE, DRAIN or DONE is ignored; there is no queueing. It is legal in the cycle after DONE.
- Timing with issue_ready held at 1, stage_start sampled at cycle 0:
  - rd_en high in cycles 1..128.
  - wr_en high in cycles 5..132.
  - stage_done in cycle 133; IDLE in cycle 134.
  - busy high in cycles 1..133.

Decomposition:
- fft_params_pkg:
  - adds ADDR_W, TW_W and STAGE_W derived from N.
  - adds the agu_state_t enum (IDLE, ISSUE, DRAIN, DONE).
  - reuses the existing N and STAGES.
- One sub-module, fft_wb_delay: a parameterised PIPE_LAT-deep shift register of {valid, addr_a, addr_b} with an any_valid output used by the DRAIN exit test.

Test Plan:
- Stage 0, issue_ready=1: first three issues (0,1,tw0), (2,3,tw0), (4,5,tw0); last issue (254,255,tw0). Exactly 128 wr_en pulses; stage_done in cycle 133.
- Stage 7: issues (0,128,tw0), (1,129,tw1) ... (127,255,tw127).
- Stage 2: k=5 gives (9,13,tw32).
- Stage 3 with issue_ready toggling 1,0,1,0:
  - rd addresses stable across stalls.
  - Each wr_en lands exactly 4 cycles after its accept.
  - 128 writes total; stage_done one cycle after the last write.
- stage_idx=3'd7 then 3'd0 back-to-back, with stage_start asserted again in the cycle after DONE: second stage accepted; no lost or extra writes.
- stage_start with stage_idx out of range (set STAGES=6, send 6): err pulses once, busy stays 0, no rd_en.
- Assert rst at cycle 60 of stage 4: outputs go to 0 immediately. No wr_en afterwards. A fresh stage_start runs all 128 butterflies normally.
